// File: rtl/amber128_uart_pkg.sv
// Shared definitions for the amber128 UART receiver and transmitter.
// Holds the state encoding, the data width and the baud divisor rounding.
package amber128_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } uart_state_e;

    // Round to the nearest whole number of clocks per bit.
    function automatic int clks_per_bit(input int freq, input int baud);
        return (freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/amber128_sync2.sv
// Generic two-flop synchroniser for a single asynchronous input.
// RESET_VAL sets the level both flops hold during reset.
module amber128_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/amber128_uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a single-entry valid/ready output.
// Framing errors and overruns are reported as one-cycle pulses.
module amber128_uart_rx
    import amber128_uart_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 27_000_000,
    parameter int BAUD_RATE     = 115_200
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      rx_i,
    output logic [UART_DATA_BITS-1:0] data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      frame_err_o,
    output logic                      overrun_o
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ_HZ, BAUD_RATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $fatal(1, "amber128_uart_rx: CLKS_PER_BIT must be at least 2");
    end

    logic                      rx_s;
    uart_state_e               state, state_n;
    logic [CNT_W-1:0]          cnt, cnt_n;
    logic [2:0]                bit_idx, bit_idx_n;
    logic [UART_DATA_BITS-1:0] shreg, shreg_n;
    logic                      deliver, frame_err;

    amber128_sync2 #(.RESET_VAL(1'b1)) u_sync_rx (
        .clk (clk_i),
        .rst (rst_i),
        .d   (rx_i),
        .q   (rx_s)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
        end
    end

    // Every path back to IDLE leaves rx_s high, so a low level there is a fresh edge.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        deliver   = 1'b0;
        frame_err = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    cnt_n   = CNT_W'(HALF_BIT - 1);
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (cnt == '0) begin
                    if (rx_s) begin
                        state_n = ST_IDLE;
                    end else begin
                        cnt_n     = CNT_W'(CLKS_PER_BIT - 1);
                        bit_idx_n = '0;
                        state_n   = ST_DATA;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt == '0) begin
                    shreg_n[bit_idx] = rx_s;
                    cnt_n            = CNT_W'(CLKS_PER_BIT - 1);
                    if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
                        state_n = ST_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt == '0) begin
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_n   = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // A byte landing on a full register is dropped unless the consumer empties it this cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= frame_err;
            overrun_o   <= deliver && valid_o && !ready_i;
            if (deliver && (!valid_o || ready_i)) begin
                data_o  <= shreg;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule
